// File: rtl/ninjin_s_axi_image.sv
// ninjin_s_axi_image: AXI4 slave mapping burst reads/writes onto the ninjin image RAM port
module ninjin_s_axi_image #(
    parameter int BWIDTH     = 32,
    parameter int MEMSIZE    = 12,
    parameter int LSB        = 2,
    parameter int DATA_WIDTH = BWIDTH,
    parameter int ADDR_WIDTH = BWIDTH,
    parameter int ID_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awlock,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic [3:0]              awqos,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic [3:0]              arqos,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    mem_we,
    output logic [MEMSIZE-1:0]      mem_waddr,
    output logic [BWIDTH-1:0]       mem_wdata,
    output logic [MEMSIZE-1:0]      mem_raddr,
    input  logic [BWIDTH-1:0]       mem_rdata
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [MEMSIZE-1:0] w_addr, r_addr;
    logic [7:0] w_cnt;
    logic [8:0] r_rem;
    logic w_bad, w_err, r_bad, pend, pend_last, beat, full, fetch, pop, pop_f, push;
    logic [1:0] occ, f_last;
    logic [BWIDTH-1:0] f_data [2];
    logic unused;
    assign unused = ^{awsize, awlock, awcache, awprot, awqos, arsize, arlock, arcache, arprot, arqos,
                      awaddr, araddr, awburst, arburst};
    assign beat = wvalid && wready;
    assign full = &wstrb;
    assign bresp = w_err ? 2'b10 : 2'b00;
    assign mem_raddr = r_addr;
    // the beat arriving from RAM bypasses the FIFO when it is empty, giving rvalid at T+2
    assign rvalid = occ != 2'd0 || pend;
    assign rdata = occ != 2'd0 ? f_data[0] : (pend ? mem_rdata : '0);
    assign rlast = occ != 2'd0 ? f_last[0] : pend && pend_last;
    assign rresp = r_bad ? 2'b10 : 2'b00;
    assign pop = rvalid && rready;
    assign pop_f = pop && occ != 2'd0;
    assign push = pend && !(pop && occ == 2'd0);
    assign fetch = r_state == R_BUSY && r_rem != 9'd0 && occ + {1'b0, pend} < 2'd2;
    always_comb begin
        w_next = w_state;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = !rst;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (wlast || w_cnt == 8'd0)) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end
    always_comb begin
        r_next = r_state;
        arready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = !rst;
                if (arvalid) r_next = R_BUSY;
            end
            R_BUSY: if (pop && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid <= '0;
            w_addr <= '0;
            w_cnt <= '0;
            w_bad <= 1'b0;
            w_err <= 1'b0;
            mem_we <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= beat && !w_bad && full;
            if (awvalid && awready) begin
                bid <= awid;
                w_addr <= awaddr[LSB +: MEMSIZE];
                w_cnt <= awlen;
                w_bad <= awburst[1];
                w_err <= awburst[1];
            end
            if (beat) begin
                w_addr <= w_addr + MEMSIZE'(1);
                w_cnt <= w_cnt - 8'd1;
                // early wlast and missing wlast both show up as wlast disagreeing with the count
                w_err <= w_err || !full || (wlast != (w_cnt == 8'd0));
                if (!w_bad && full) begin
                    mem_waddr <= w_addr;
                    mem_wdata <= wdata;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rid <= '0;
            r_addr <= '0;
            r_rem <= '0;
            r_bad <= 1'b0;
            pend <= 1'b0;
            pend_last <= 1'b0;
            occ <= '0;
            f_last <= '0;
            f_data[0] <= '0;
            f_data[1] <= '0;
        end else begin
            pend <= fetch;
            pend_last <= fetch && r_rem == 9'd1;
            if (arvalid && arready) begin
                rid <= arid;
                r_addr <= araddr[LSB +: MEMSIZE];
                r_rem <= {1'b0, arlen} + 9'd1;
                r_bad <= arburst[1];
            end
            if (fetch) begin
                r_addr <= r_addr + MEMSIZE'(1);
                r_rem <= r_rem - 9'd1;
            end
            if (pop_f) begin
                f_data[0] <= f_data[1];
                f_last[0] <= f_last[1];
            end
            if (push) begin
                f_data[occ[0] && !pop_f] <= mem_rdata;
                f_last[occ[0] && !pop_f] <= pend_last;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop_f};
        end
    end
endmodule

// File: tb/tb_ninjin_s_axi_image.sv
// tb_ninjin_s_axi_image: directed scoreboard bench for the AXI image slave
module tb_ninjin_s_axi_image;
    localparam int MS = 8, LSB = 2, DW = 32, AW = 32, IW = 12;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [IW-1:0] awid = '0, arid = '0, bid, rid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0;
    logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
    logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b1, rready = 1'b1;
    logic [DW-1:0] wdata = '0, rdata;
    logic [DW/8-1:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, rlast, mem_we;
    logic [MS-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, rd_q;
    ninjin_s_axi_image #(.BWIDTH(DW), .MEMSIZE(MS), .LSB(LSB), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(awburst), .awlock(1'b0),
        .awcache(4'd0), .awprot(3'd0), .awqos(4'd0), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(arburst), .arlock(1'b0),
        .arcache(4'd0), .arprot(3'd0), .arqos(4'd0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(rd_q)
    );
    // 1-cycle-latency RAM; unwritten words read as a fixed address pattern
    logic [DW-1:0] ram [256];
    bit wrn [256];
    logic [DW-1:0] sh [256];
    function automatic logic [DW-1:0] pat(input logic [MS-1:0] a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction
    always @(posedge clk) begin
        rd_q <= wrn[mem_raddr] ? ram[mem_raddr] : pat(mem_raddr);
        if (mem_we) begin
            ram[mem_waddr] <= mem_wdata;
            wrn[mem_waddr] <= 1'b1;
        end
    end
    int n_chk = 0, n_pass = 0, cyc = 0, ar_cyc = 0, done_cyc = 0, r_beats = 0;
    logic [63:0] wq[$], bq[$], rq[$];
    logic stall = 1'b0;
    logic [35:0] held = '0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask
    always @(negedge clk) begin
        if (rst) stall <= 1'b0;
        else begin
            if (stall) chk("r_hold", {rvalid, rdata, rlast, rresp}, held);
            stall <= rvalid && !rready;
            held <= {rvalid, rdata, rlast, rresp};
            if (arvalid && arready) ar_cyc <= cyc;
            if (mem_we) begin
                chk("we_expected", 64'(wq.size() != 0), 1);
                if (wq.size() != 0) chk("we", {mem_waddr, mem_wdata}, wq.pop_front());
            end
            if (bvalid && bready) begin
                chk("b_expected", 64'(bq.size() != 0), 1);
                if (bq.size() != 0) chk("b", {bid, bresp}, bq.pop_front());
            end
            if (rvalid && rready) begin
                chk("r_expected", 64'(rq.size() != 0), 1);
                if (rq.size() != 0) chk("r", {rdata, rlast, rresp}, rq.pop_front());
                r_beats <= r_beats + 1;
                if (rlast) done_cyc <= cyc;
            end
        end
    end
    function automatic logic sig(input int s);
        return s == 0 ? awready : s == 1 ? wready : s == 2 ? arready : bvalid;
    endfunction
    task automatic await(input string tag, input int s);
        int k;
        k = 0;
        @(negedge clk);
        while (!sig(s) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(sig(s)), 1);
    endtask
    task automatic wr(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input int nb, input int sb, input int lb, input logic [DW-1:0] base);
        logic [MS-1:0] w, a;
        logic err;
        w = addr[LSB +: MS];
        err = burst[1] || sb != 0 || lb != int'(len) + 1;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        await("aw_hs", 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        bq.push_back({50'd0, id, err ? 2'b10 : 2'b00});
        for (int i = 1; i <= nb; i++) begin
            wdata = base + DW'(i - 1);
            wstrb = i == sb ? 4'h7 : 4'hF;
            wlast = i == lb;
            wvalid = 1'b1;
            a = w + MS'(i - 1);
            if (!burst[1] && i != sb) begin
                wq.push_back({a, wdata});
                sh[a] = wdata;
            end
            await("w_hs", 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask
    task automatic rd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [MS-1:0] w;
        w = addr[LSB +: MS];
        for (int i = 0; i <= int'(len); i++)
            rq.push_back({sh[w + MS'(i)], i == int'(len), burst[1] ? 2'b10 : 2'b00});
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        await("ar_hs", 2);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask
    task automatic drain(input string tag);
        int k;
        k = 0;
        while (wq.size() + bq.size() + rq.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 64'(wq.size() + bq.size() + rq.size()), 0);
    endtask
    initial begin
        int base;
        for (int i = 0; i < 256; i++) sh[i] = pat(MS'(i));
        repeat (3) @(negedge clk);
        chk("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast, mem_we, bresp, rresp}, 0);
        chk("rst_data", {rdata, mem_waddr, mem_raddr}, 0);
        chk("rst_ids", {bid, rid, mem_wdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", {awready, arready}, 2'b11);
        @(posedge clk); #1;
        wr(12'h123, 32'h40, 8'd3, 2'b01, 4, 0, 4, 32'd1);
        drain("incr_write");
        rd(12'h045, 32'h40, 8'd255, 2'b01);
        drain("incr_read");
        chk("rd_latency", 64'(done_cyc - ar_cyc), 257);
        chk("ar_return", 64'(arready), 1);
        rd(12'h077, 32'h200, 8'd7, 2'b01);
        for (int c = 0; c < 300 && rq.size() != 0; c++) begin
            rready = (c >= 3 && c < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rready = 1'b1;
        drain("backpressure");
        wr(12'h201, 32'h100, 8'd1, 2'b10, 2, 0, 2, 32'h2000);
        wr(12'h202, 32'h110, 8'd2, 2'b01, 3, 2, 3, 32'h3000);
        wr(12'h203, 32'h120, 8'd3, 2'b01, 2, 0, 2, 32'h4000);
        wr(12'h204, 32'h130, 8'd1, 2'b01, 2, 0, 0, 32'h5000);
        drain("err_writes");
        rd(12'h205, 32'h100, 8'd15, 2'b01);
        rd(12'h009, 32'h300, 8'd1, 2'b10);
        drain("err_reads");
        bready = 1'b0;
        fork
            wr(12'h0A1, 32'h80, 8'd15, 2'b01, 16, 0, 16, 32'h1000);
            rd(12'h0B2, 32'h180, 8'd15, 2'b01);
        join
        await("b_wait", 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("b_hold", {bvalid, bid, bresp}, {1'b1, 12'h0A1, 2'b00});
        end
        @(posedge clk); #1;
        bready = 1'b1;
        drain("concurrent");
        base = r_beats;
        rd(12'h033, 32'h80, 8'd7, 2'b01);
        for (int k = 0; k < 100 && r_beats - base < 3; k++) @(posedge clk);
        chk("rst_point", 64'(r_beats - base), 3);
        #1;
        rst = 1'b1;
        rq.delete();
        @(negedge clk);
        chk("mid_rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast, mem_we, bresp, rresp}, 0);
        chk("mid_rst_data", {rdata, mem_raddr, rid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd(12'h034, 32'h84, 8'd0, 2'b01);
        drain("after_reset");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
